// File: rtl/arb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_sched_pkg
// Purpose  : Shared types and sizing constants for the 4-way grant scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package arb_sched_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/prio_enc4_rot.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc4_rot
// Purpose  : 4-input priority encoder; index `rot` has highest priority, then
//            descending with wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc4_rot
  import arb_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rot,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  logic [IDX_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = rot - IDX_W'(k);
      if (req[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_sched_4.sv
`default_nettype none
// ============================================================================
// Module   : arb_sched_4
// Purpose  : 4-requester grant scheduler, fixed-priority or round-robin, with
//            a hold-time limit and one-shot exclusion of a timed-out holder.
// Revision : 1.0 - initial release
// ============================================================================
module arb_sched_4
  import arb_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD     = 16,
  parameter logic [1:0]  RR_RESET_PTR = 2'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rr_mode,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       hold_q, hold_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             blk_vld_q, blk_vld_d;
  logic [IDX_W-1:0] blk_id_q, blk_id_d;

  logic [N_REQ-1:0] blk_mask, req_excl, arb_req;
  logic [IDX_W-1:0] arb_rot, arb_idx;
  logic             arb_vld, rel_other, expire;

  // A timed-out holder is skipped once, unless it is the only requester.
  assign blk_mask = blk_vld_q ? (N_REQ'(1) << blk_id_q) : '0;
  assign req_excl = req & ~blk_mask;
  assign arb_req  = (req_excl != '0) ? req_excl : req;
  assign arb_rot  = rr_mode ? (ptr_q - IDX_W'(1)) : IDX_W'(N_REQ - 1);

  prio_enc4_rot u_prio_enc (
    .req (arb_req),
    .rot (arb_rot),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign rel_other = !req[gnt_id_q] || done || !en;
  assign expire    = (hold_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_d      = hold_q;
    ptr_d       = ptr_q;
    blk_vld_d   = blk_vld_q;
    blk_id_d    = blk_id_q;
    case (state_q)
      IDLE: begin
        if (en && arb_vld) begin
          state_d     = GRANT;
          gnt_d       = N_REQ'(1) << arb_idx;
          gnt_id_d    = arb_idx;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
          ptr_d       = arb_idx;
          blk_vld_d   = 1'b0;
        end
      end
      GRANT: begin
        if (rel_other || expire) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          hold_d      = '0;
          timeout_d   = expire && !rel_other;
          if (timeout_d) begin
            blk_vld_d = 1'b1;
            blk_id_d  = gnt_id_q;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_q      <= '0;
      ptr_q       <= RR_RESET_PTR;
      blk_vld_q   <= 1'b0;
      blk_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
      blk_vld_q   <= blk_vld_d;
      blk_id_q    <= blk_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_sched_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_sched_4
// Purpose  : Directed and random checks of arb_sched_4 against a rule-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_sched_4;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rr_mode = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: holder index (-1 = none), cycles held, pointer, excluded index.
  int m_holder  = -1;
  int m_hold    = 0;
  int m_ptr     = 3;
  int m_blocked = -1;
  bit m_tmo     = 1'b0;

  int         run_len = 0;
  logic [3:0] prev_gnt = 4'b0000;

  arb_sched_4 #(.MAX_HOLD(MH), .RR_RESET_PTR(2'd3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rr_mode   (rr_mode),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] r, input bit rr, input int ptr, input int blk);
    logic [3:0] cand;
    logic [3:0] x;
    int         idx;
    cand = r;
    if (blk >= 0) begin
      x = r;
      x[blk] = 1'b0;
      if (x != 4'b0000) cand = x;
    end
    for (int k = 0; k < 4; k++) begin
      idx = rr ? (ptr + 3 - k) % 4 : 3 - k;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic t_rst, t_en, t_rr, input logic [3:0] t_req, input logic t_done);
    bit other;
    bit exp_hit;
    int w;
    if (t_rst) begin
      m_holder = -1; m_hold = 0; m_ptr = 3; m_blocked = -1; m_tmo = 1'b0;
    end else if (m_holder < 0) begin
      m_tmo = 1'b0;
      w = pick(t_req, t_rr, m_ptr, m_blocked);
      if (t_en && w >= 0) begin
        m_holder = w; m_hold = 0; m_ptr = w; m_blocked = -1;
      end
    end else begin
      other   = !t_req[m_holder] || t_done || !t_en;
      exp_hit = (m_hold == MH - 1);
      if (other || exp_hit) begin
        m_tmo = exp_hit && !other;
        if (m_tmo) m_blocked = m_holder;
        m_holder = -1;
        m_hold   = 0;
      end else begin
        m_tmo  = 1'b0;
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic tick(input logic t_rst, t_en, t_rr, input logic [3:0] t_req, input logic t_done);
    logic [3:0] eg;
    @(negedge clk);
    rst = t_rst; en = t_en; rr_mode = t_rr; req = t_req; done = t_done;
    model_step(t_rst, t_en, t_rr, t_req, t_done);
    @(posedge clk);
    #1;
    eg = (m_holder < 0) ? 4'b0000 : (4'b0001 << m_holder);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_valid", 32'(gnt_valid), 32'(m_holder >= 0));
    check("timeout", 32'(timeout), 32'(m_tmo));
    if (m_holder >= 0) check("gnt_id", 32'(gnt_id), 32'(m_holder));
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
    if (gnt != 4'b0000 && gnt == prev_gnt) run_len++;
    else run_len = (gnt != 4'b0000) ? 1 : 0;
    prev_gnt = gnt;
    check("hold_len", 32'(run_len <= MH), 32'd1);
  endtask

  int         order [5] = '{2, 1, 0, 3, 2};
  logic [3:0] rq;
  logic       r_en, r_rr, r_done, r_rst;

  initial begin
    // Reset state
    tick(1, 0, 0, 4'b0000, 0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Fixed mode, req 0110, req[2] dropped at cycle 4
    tick(0, 1, 0, 4'b0110, 0);
    check("fp_c1_gnt", 32'(gnt), 32'b0100);
    check("fp_c1_id", 32'(gnt_id), 32'd2);
    tick(0, 1, 0, 4'b0110, 0);
    tick(0, 1, 0, 4'b0110, 0);
    tick(0, 1, 0, 4'b0010, 0);
    check("fp_c5_gnt", 32'(gnt), 32'd0);
    check("fp_c5_tmo", 32'(timeout), 32'd0);
    tick(0, 1, 0, 4'b0010, 0);
    check("fp_c6_gnt", 32'(gnt), 32'b0010);

    // Round-robin order from reset pointer
    tick(1, 0, 1, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 1, 4'b1111, 0);
      check("rr_order", 32'(gnt_id), 32'(order[i]));
      tick(0, 1, 1, 4'b1111, 1);
      check("rr_dead", 32'(gnt), 32'd0);
    end

    // Hold expiry with req 1001
    tick(1, 0, 0, 4'b0000, 0);
    for (int c = 1; c <= 4; c++) begin
      tick(0, 1, 0, 4'b1001, 0);
      check("to_hold_gnt", 32'(gnt), 32'b1000);
    end
    tick(0, 1, 0, 4'b1001, 0);
    check("to_c5_tmo", 32'(timeout), 32'd1);
    check("to_c5_gnt", 32'(gnt), 32'd0);
    tick(0, 1, 0, 4'b1001, 0);
    check("to_c6_gnt", 32'(gnt), 32'b0001);
    check("to_c6_tmo", 32'(timeout), 32'd0);

    // done coincident with expiry: single release, no timeout
    tick(1, 0, 0, 4'b0000, 0);
    for (int c = 1; c <= 4; c++) tick(0, 1, 0, 4'b1000, 0);
    tick(0, 1, 0, 4'b1000, 1);
    check("dx_gnt", 32'(gnt), 32'd0);
    check("dx_tmo", 32'(timeout), 32'd0);
    tick(0, 1, 0, 4'b1000, 0);
    check("dx_regrant", 32'(gnt), 32'b1000);

    // Reset mid-grant, then en low
    tick(1, 0, 0, 4'b0000, 0);
    tick(0, 1, 0, 4'b0010, 0);
    check("mr_gnt", 32'(gnt), 32'b0010);
    tick(1, 1, 0, 4'b0010, 0);
    check("mr_gnt0", 32'(gnt), 32'd0);
    check("mr_valid0", 32'(gnt_valid), 32'd0);
    check("mr_id0", 32'(gnt_id), 32'd0);
    check("mr_tmo0", 32'(timeout), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick(0, 0, 0, 4'b1111, 0);
      check("en_low_gnt", 32'(gnt), 32'd0);
    end

    // Random traffic
    rq = 4'b0000; r_rr = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
      if ($urandom_range(0, 49) == 0) r_rr = ~r_rr;
      r_en   = ($urandom_range(0, 19) != 0);
      r_done = ($urandom_range(0, 9) == 0);
      r_rst  = ($urandom_range(0, 199) == 0);
      tick(r_rst, r_en, r_rr, rq, r_done);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
